// File: rtl/thermo_pkg.sv
// Shared thermometer-code helpers, used by the streaming codec and the legacy
// combinational encoder/decoder pair.
package thermo_pkg;

    localparam int K_DEFAULT   = 5;
    // Functions operate on a fixed-width container. Callers pass the live width w.
    localparam int THERM_MAX_W = 255;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    typedef logic [THERM_MAX_W-1:0] therm_t;

    function automatic int therm_w(input int k);
        return (1 << k) - 1;
    endfunction

    function automatic therm_t therm_encode(input int a, input int w);
        therm_t r;
        r = '0;
        for (int i = 0; i < THERM_MAX_W; i++)
            r[i] = (i < w) && (i < a);
        return r;
    endfunction

    function automatic int therm_popcount(input therm_t code, input int w);
        int n;
        n = 0;
        for (int i = 0; i < THERM_MAX_W; i++)
            if ((i < w) && code[i])
                n++;
        return n;
    endfunction

    // Length of the unbroken run of ones starting at bit 0.
    function automatic int therm_strict(input therm_t code, input int w);
        int n;
        bit run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < THERM_MAX_W; i++) begin
            if (run && (i < w) && code[i])
                n++;
            else
                run = 1'b0;
        end
        return n;
    endfunction

    function automatic bit therm_malformed(input therm_t code, input int w);
        bit seen_zero;
        bit bad;
        seen_zero = 1'b0;
        bad       = 1'b0;
        for (int i = 0; i < THERM_MAX_W; i++) begin
            if (i < w) begin
                if (!code[i])
                    seen_zero = 1'b1;
                else if (seen_zero)
                    bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/thermo_pipe_slice.sv
// One valid/ready register stage. It reloads whenever it is empty or its
// contents leave this cycle, so back-to-back transfers run at full rate.
module thermo_pipe_slice #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    logic load;

    assign load     = !out_valid || out_ready;
    assign in_ready = load;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/thermometer_codec_stream.sv
// Two-stage handshaked thermometer encoder/decoder with per-beat mode, bubble
// detection and a saturating malformed-beat counter.
module thermometer_codec_stream
    import thermo_pkg::*;
#(
    parameter int K          = K_DEFAULT,
    parameter int W          = therm_w(K),
    parameter bit BUBBLE_FIX = 1'b1,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [W-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_mode,
    output logic [W-1:0]         out_data,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    if (W != therm_w(K) || W > THERM_MAX_W) begin : g_bad_width
        $error("thermometer_codec_stream: W must equal 2**K-1 and not exceed THERM_MAX_W");
    end

    typedef struct packed {
        mode_e        mode;
        logic         mal;
        logic [W-1:0] data;
    } s1_t;

    typedef struct packed {
        mode_e        mode;
        logic         err;
        logic [W-1:0] data;
    } s2_t;

    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic v1, v2;
    logic s2_in_ready;

    // Bubble detection runs on the raw input so S2 only has to pick a result.
    always_comb begin
        s1_d      = '0;
        s1_d.mode = mode_e'(in_mode);
        s1_d.data = in_data;
        s1_d.mal  = therm_malformed(therm_t'(in_data), W);
    end

    thermo_pipe_slice #(.PW($bits(s1_t))) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_d),
        .out_valid (v1),
        .out_ready (s2_in_ready),
        .out_data  (s1_q)
    );

    always_comb begin
        s2_d      = '0;
        s2_d.mode = s1_q.mode;
        if (s1_q.mode == MODE_ENC) begin
            s2_d.data = W'(therm_encode(int'(s1_q.data[K-1:0]), W));
        end else begin
            s2_d.err = s1_q.mal;
            if (BUBBLE_FIX)
                s2_d.data[K-1:0] = K'(therm_popcount(therm_t'(s1_q.data), W));
            else
                s2_d.data[K-1:0] = K'(therm_strict(therm_t'(s1_q.data), W));
        end
    end

    thermo_pipe_slice #(.PW($bits(s2_t))) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .in_ready  (s2_in_ready),
        .in_data   (s2_d),
        .out_valid (v2),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign out_valid = v2;
    assign out_mode  = s2_q.mode;
    assign out_data  = s2_q.data;
    assign out_err   = s2_q.err;

    // Counted on output completion so a stalled beat is counted exactly once.
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if (v2 && out_ready && s2_q.err && (err_cnt != {ERR_CNT_W{1'b1}}))
            err_cnt <= err_cnt + 1'b1;
    end

endmodule

// File: tb/tb_thermometer_codec_stream.sv
// Directed and randomized checks of thermometer_codec_stream against a queue-based model.
module tb_thermometer_codec_stream;

    localparam int K = 5;
    localparam int W = 31;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_mode, out_ready;
    logic [W-1:0] in_data;

    logic in_ready, out_valid, out_mode, out_err;
    logic [W-1:0] out_data;
    logic [15:0] err_cnt;
    logic in_ready_s, out_valid_s, out_mode_s, out_err_s;
    logic [W-1:0] out_data_s;
    logic [15:0] err_cnt_s;
    logic in_ready_c, out_valid_c, out_mode_c, out_err_c;
    logic [W-1:0] out_data_c;
    logic [1:0] err_cnt_c;

    always #5 clk = ~clk;

    thermometer_codec_stream #(.K(K), .W(W), .BUBBLE_FIX(1'b1), .ERR_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_data(out_data), .out_err(out_err), .err_cnt(err_cnt));

    thermometer_codec_stream #(.K(K), .W(W), .BUBBLE_FIX(1'b0), .ERR_CNT_W(16)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready), .out_mode(out_mode_s),
        .out_data(out_data_s), .out_err(out_err_s), .err_cnt(err_cnt_s));

    thermometer_codec_stream #(.K(K), .W(W), .BUBBLE_FIX(1'b1), .ERR_CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid_c), .out_ready(out_ready), .out_mode(out_mode_c),
        .out_data(out_data_c), .out_err(out_err_c), .err_cnt(err_cnt_c));

    typedef struct {
        logic         mode;
        logic [W-1:0] pop_data;
        logic [W-1:0] strict_data;
        logic         err;
    } beat_t;

    beat_t q[$];
    int checks = 0;
    int errors = 0;
    int m_cnt = 0;
    int m_cnt_c = 0;
    logic hold_prev = 1'b0;
    logic [W-1:0] hold_data;
    logic hold_mode, hold_err;
    logic fired = 1'b0;
    logic last_in_ready = 1'b0;
    logic [W-1:0] got_main, got_strict;
    logic got_err, got_mode;

    function automatic beat_t model(input logic mode, input logic [W-1:0] d);
        beat_t b;
        int ones;
        int t;
        bit run;
        ones = $countones(d);
        t = 0;
        run = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (run && d[i]) t++;
            else run = 1'b0;
        end
        b.mode = mode;
        if (!mode) begin
            b.pop_data    = W'((64'd1 << d[K-1:0]) - 64'd1);
            b.strict_data = b.pop_data;
            b.err         = 1'b0;
        end else begin
            b.pop_data    = W'(ones);
            b.strict_data = W'(t);
            b.err         = (d != W'((64'd1 << ones) - 64'd1));
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, settle, check against the model, step past the edge.
    task automatic cycle(input logic v, input logic mode, input logic [W-1:0] d, input logic ordy);
        beat_t e;
        in_valid  = v;
        in_mode   = mode;
        in_data   = d;
        out_ready = ordy;
        #1;
        chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || ordy));
        chk("sync_valid", 64'({out_valid_s, out_valid_c}), 64'({out_valid, out_valid}));
        if (q.size() == 0) chk("idle_valid", 64'(out_valid), 64'd0);
        if (hold_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_beat", 64'({out_mode, out_err, out_data}), 64'({hold_mode, hold_err, hold_data}));
        end
        chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
        chk("err_cnt_s", 64'(err_cnt_s), 64'(m_cnt));
        chk("err_cnt_c", 64'(err_cnt_c), 64'(m_cnt_c));
        last_in_ready = in_ready;
        fired = out_valid && ordy;
        if (fired) begin
            got_main = out_data; got_strict = out_data_s; got_err = out_err; got_mode = out_mode;
            if (q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = q.pop_front();
                chk("out_data", 64'(out_data), 64'(e.pop_data));
                chk("out_data_strict", 64'(out_data_s), 64'(e.strict_data));
                chk("out_data_c", 64'(out_data_c), 64'(e.pop_data));
                chk("out_mode", 64'(out_mode), 64'(e.mode));
                chk("out_err", 64'(out_err), 64'(e.err));
                chk("out_err_s", 64'(out_err_s), 64'(e.err));
                if (e.err) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt_c < 3) m_cnt_c++;
                end
            end
        end
        if (v && in_ready) q.push_back(model(mode, d));
        hold_prev = out_valid && !ordy;
        hold_data = out_data; hold_mode = out_mode; hold_err = out_err;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b1; in_mode = 1'b1; in_data = W'(32'h0B); out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        q.delete();
        m_cnt = 0; m_cnt_c = 0; hold_prev = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_mode", 64'(out_mode), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_err_cnt_c", 64'(err_cnt_c), 64'd0);
    endtask

    // Single beat into an empty pipe; lat = edges from acceptance to output transfer.
    task automatic send(input logic mode, input logic [W-1:0] d, output int lat);
        cycle(1'b1, mode, d, 1'b1);
        lat = 0;
        for (int n = 1; n <= 8 && !fired; n++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            lat = n;
        end
    endtask

    initial begin
        int lat;
        int n;
        int sat_exp [5];
        logic [W-1:0] sat_in [5];
        logic v, m, r;
        logic [W-1:0] d;

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
        do_reset();

        send(1'b0, W'(0), lat);
        chk("enc0_lat", 64'(lat), 64'd2);
        chk("enc0", 64'(got_main), 64'h0);
        chk("enc0_err", 64'(got_err), 64'd0);
        send(1'b0, W'(5), lat);
        chk("enc5", 64'(got_main), 64'h1F);
        chk("enc5_err", 64'(got_err), 64'd0);
        send(1'b0, W'(32'h2AAA_AAFF), lat);
        chk("enc31", 64'(got_main), 64'h7FFF_FFFF);
        chk("enc31_err", 64'(got_err), 64'd0);

        send(1'b1, W'(32'hFF), lat);
        chk("dec_ff", 64'(got_main), 64'd8);
        chk("dec_ff_strict", 64'(got_strict), 64'd8);
        chk("dec_ff_err", 64'(got_err), 64'd0);
        chk("dec_ff_cnt", 64'(err_cnt), 64'd0);

        send(1'b1, W'(32'h0B), lat);
        chk("bub_pop", 64'(got_main), 64'd3);
        chk("bub_strict", 64'(got_strict), 64'd2);
        chk("bub_err", 64'(got_err), 64'd1);
        chk("bub_cnt", 64'(err_cnt), 64'd1);

        // Backpressure: two beats fill the pipe, the third waits.
        cycle(1'b1, 1'b0, W'(7), 1'b0);
        chk("bp_acc1", 64'(last_in_ready), 64'd1);
        cycle(1'b1, 1'b1, W'(3), 1'b0);
        chk("bp_acc2", 64'(last_in_ready), 64'd1);
        cycle(1'b1, 1'b0, W'(31), 1'b0);
        chk("bp_full", 64'(last_in_ready), 64'd0);
        cycle(1'b1, 1'b0, W'(31), 1'b0);
        chk("bp_full2", 64'(last_in_ready), 64'd0);
        cycle(1'b1, 1'b0, W'(31), 1'b1);
        chk("bp_rel_acc", 64'(last_in_ready), 64'd1);
        chk("bp_out1_fire", 64'(fired), 64'd1);
        chk("bp_out1", 64'(got_main), 64'h7F);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("bp_out2_fire", 64'(fired), 64'd1);
        chk("bp_out2", 64'(got_main), 64'd2);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("bp_out3_fire", 64'(fired), 64'd1);
        chk("bp_out3", 64'(got_main), 64'h7FFF_FFFF);

        // Reset with two beats in flight.
        cycle(1'b1, 1'b1, W'(32'h0B), 1'b0);
        cycle(1'b1, 1'b1, W'(32'h05), 1'b0);
        do_reset();
        send(1'b0, W'(9), lat);
        chk("post_rst_lat", 64'(lat), 64'd2);
        chk("post_rst_data", 64'(got_main), 64'h1FF);

        sat_exp = '{1, 2, 3, 3, 3};
        sat_in  = '{W'(32'h0B), W'(32'h05), W'(32'h100), W'(32'h2), W'(32'h7FFF_FFFE)};
        for (int k = 0; k < 5; k++) begin
            send(1'b1, sat_in[k], lat);
            chk("sat_cnt", 64'(err_cnt_c), 64'(sat_exp[k]));
        end

        for (int c = 0; c < 3000; c++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            m = 1'($urandom_range(0, 1));
            if (m && ($urandom_range(0, 2) == 0))
                d = W'((64'd1 << $urandom_range(0, 31)) - 64'd1);
            else
                d = W'($urandom);
            cycle(v, m, d, r);
        end
        n = 0;
        while (q.size() > 0 && n < 50) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/thermometer_codec_stream.md
# thermometer_codec_stream

Pipelined, handshaked thermometer codec for parametrised widths. Each beat carries its own mode: either a K-bit binary value becomes a W-bit thermometer code, or a W-bit thermometer code becomes a K-bit binary value. Decoding flags malformed codes (bubbles), optionally corrects them, and keeps a saturating error count. It replaces the standalone combinational encoder/decoder pair inside clocked datapaths that need flow control.

## Interface
- K, default 5: binary width.
- W, default 2**K-1: thermometer width; must equal 2**K-1 (elaboration check).
- BUBBLE_FIX, default 1: decode mode. 1 = population count (bubble-tolerant); 0 = strict count of contiguous ones from bit 0.
- ERR_CNT_W, default 16: width of the error counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_mode  in  1  0 = encode, 1 = decode; sampled with the beat
- in_data  in  W  encode: value in [K-1:0], upper bits ignored; decode: thermometer code
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_mode  out  1  mode of the output beat
- out_data  out  W  encode: thermometer code; decode: result in [K-1:0], upper bits 0
- out_err  out  1  decode beat was malformed; always 0 for encode beats
- err_cnt  out  ERR_CNT_W  count of malformed decode beats; saturates at all-ones

## Operation
- Two-stage register pipeline.
  - S1 captures mode, data, and the malformed flag.
  - S2 holds the computed result.
- Encode of value a (0..W): out_data[i] = 1 for i < a, else 0. Examples: a=0 gives all zeros; a=W gives all ones.
- Malformed code: some bit i is 1 while a lower bit j < i is 0.
- Decode result:
  - BUBBLE_FIX=1: popcount of in_data.
  - BUBBLE_FIX=0: index of the lowest 0 bit (W if all ones).
  - A well-formed code gives the same result in both modes.
- err_cnt increments by 1 when a beat with out_err=1 completes its output handshake (out_valid && out_ready). It holds at 2**ERR_CNT_W-1 once saturated.
- Beats never reorder, drop, or duplicate. Mode may change on every beat.

## Timing
- Handshake: a transfer occurs on a rising edge where valid && ready. Once out_valid is asserted, out_valid, out_data, out_mode and out_err stay stable until the transfer.
- Load conditions:
  - s2_load = !v2 || out_ready
  - s1_load = !v1 || s2_load
  - in_ready = s1_load, combinational from out_ready
- Latency: a beat accepted at edge N is presented with out_valid=1 after edge N+1 when S2 is free. It can complete a transfer at edge N+2 at the earliest.
- Throughput: one beat per cycle while out_ready=1.
- Full: with both stages occupied and out_ready=0, in_ready=0.
- Simultaneous input and output handshakes in the same cycle are legal and preserve full throughput.
- Reset:
  - Outputs after the reset edge: v1=v2=0, out_valid=0, in_ready=1, out_data=0, out_mode=0, out_err=0, err_cnt=0.
  - A reset mid-stream discards all in-flight beats. in_valid is ignored while rst=1.

## Structure
- Shared package thermo_pkg holds:
  - constant K_DEFAULT=5
  - function therm_w(k) returning 2**k-1
  - functions therm_encode, therm_popcount, therm_strict, therm_malformed, shared with the legacy encoder/decoder
- One sub-module, thermo_pipe_slice: a single valid/ready register slice parametrised by payload width, instantiated twice.
- Control, datapath functions and the error counter live in the top module.

## Test plan
Use K=5, W=31.
- **Encode:** send 0, 5, 31 in encode mode → out_data 0x00000000, 0x0000001F, 0x7FFFFFFF; out_err=0 on all three.
- **Decode, well-formed:** send 0x000000FF in decode mode → out_data=8, out_err=0, err_cnt unchanged.
- **Decode, bubble:** send 0x0000000B.
  - BUBBLE_FIX=1 → out_data=3, out_err=1, err_cnt 0→1.
  - BUBBLE_FIX=0 → out_data=2, out_err=1.
- **Backpressure:** hold out_ready=0 and offer 3 back-to-back beats → in_ready drops after 2 beats are accepted. Release out_ready → all 3 beats emerge in order with stable data, one per cycle.
- **Reset mid-stream:** assert rst for one cycle with 2 beats in flight → out_valid=0 and err_cnt=0 after the edge. Next accepted beat is output correctly 2 edges later.
- **Saturation, with ERR_CNT_W=2:** send 5 malformed decode beats → err_cnt reads 1, 2, 3, 3, 3.
